// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
// Purpose: op encodings, FSM state encoding, datapath width and iteration count.
package hilo_pkg;

    localparam int HILO_W    = 32;
    localparam int HILO_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } hilo_state_t;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - one restoring-division step
// Purpose: shift the next dividend bit into the partial remainder and try to
//          subtract the divisor.
// Ports:   rem_i          - current 33-bit partial remainder
//          divisor_i      - divisor magnitude
//          dividend_bit_i - next dividend bit (MSB first)
//          rem_o          - next partial remainder
//          q_bit_o        - quotient bit produced by this step
module div_iter
    import hilo_pkg::*;
(
    input  logic [HILO_W:0]   rem_i,
    input  logic [HILO_W-1:0] divisor_i,
    input  logic              dividend_bit_i,
    output logic [HILO_W:0]   rem_o,
    output logic              q_bit_o
);

    logic [HILO_W:0] shifted;

    // rem_i[HILO_W] set would mean the shifted value exceeds 2^33, which is
    // always >= divisor; the subtraction modulo 2^33 is still exact.
    always_comb begin
        shifted = {rem_i[HILO_W-1:0], dividend_bit_i};
        q_bit_o = rem_i[HILO_W] | (shifted >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (shifted - {1'b0, divisor_i}) : shifted;
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Purpose: sign handling, shift-add multiply, restoring divide (via div_iter),
//          MTHI/MTLO and the architectural HI/LO registers.
// Ports:   clk, rst_n (async, active-low); start/op/a/b request;
//          busy, done, div_by_zero status; hi/lo register outputs.
// Macro:   HILO_FAST_MULT_EN - single-cycle native multiply instead of the
//          iterative shift-add path.
module hilo_muldiv_unit
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [HILO_W-1:0] a,
    input  logic [HILO_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo
);

    hilo_state_t         state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*HILO_W-1:0] acc_q, acc_d;      // MUL: product|multiplier, DIV: low half dividend|quotient
    logic [HILO_W:0]     rem_q, rem_d;
    logic [HILO_W-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
    logic                neg_q, neg_d;      // product / quotient sign
    logic                rneg_q, rneg_d;    // remainder sign
    logic                divop_q, divop_d;
    logic [HILO_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d, dbz_q, dbz_d;

    hilo_op_t            op_e;
    logic                is_mul, is_div, is_signed, accept;
    logic [HILO_W-1:0]   a_mag, b_mag;
    logic [HILO_W:0]     mul_sum;
    logic [2*HILO_W-1:0] prod_fix;
    logic [HILO_W:0]     div_rem;
    logic                div_q;

    assign op_e      = hilo_op_t'(op);
    assign is_mul    = (op_e == OP_MULT) || (op_e == OP_MULTU);
    assign is_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
    assign is_signed = ~op[0];
    assign accept    = start && (state_q == IDLE) && (op_e != OP_NOP6) && (op_e != OP_NOP7);
    assign a_mag     = (is_signed && a[HILO_W-1]) ? -a : a;
    assign b_mag     = (is_signed && b[HILO_W-1]) ? -b : b;

    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the whole accumulator right, carry included.
    assign mul_sum   = {1'b0, acc_q[2*HILO_W-1:HILO_W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign prod_fix  = neg_q ? -acc_q : acc_q;

`ifdef HILO_FAST_MULT_EN
    logic [2*HILO_W-1:0] ext_a, ext_b, fast_prod;
    // Sign extension to 64 bits makes the truncated unsigned product correct for MULT too.
    assign ext_a     = is_signed ? {{HILO_W{a[HILO_W-1]}}, a} : {{HILO_W{1'b0}}, a};
    assign ext_b     = is_signed ? {{HILO_W{b[HILO_W-1]}}, b} : {{HILO_W{1'b0}}, b};
    assign fast_prod = ext_a * ext_b;
`endif

    div_iter u_div_iter (
        .rem_i          (rem_q),
        .divisor_i      (opd_q),
        .dividend_bit_i (acc_q[HILO_W-1]),
        .rem_o          (div_rem),
        .q_bit_o        (div_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef HILO_FAST_MULT_EN
                    if (is_div && (b != '0)) state_d = DIV;
`else
                    if (is_mul)                   state_d = MUL;
                    else if (is_div && (b != '0)) state_d = DIV;
`endif
                end
            end
            MUL, DIV: if (cnt_q == '0) state_d = FIX;
            FIX:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        divop_d = divop_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d   = 1'b0;
                    cnt_d   = 5'(HILO_ITER - 1);
                    neg_d   = is_signed & (a[HILO_W-1] ^ b[HILO_W-1]);
                    rneg_d  = is_signed & a[HILO_W-1];
                    divop_d = is_div;
                    if (is_mul) begin
`ifdef HILO_FAST_MULT_EN
                        {hi_d, lo_d} = fast_prod;
                        done_d       = 1'b1;
`else
                        acc_d = {{HILO_W{1'b0}}, b_mag};
                        opd_d = a_mag;
`endif
                    end else if (is_div) begin
                        if (b == '0) begin
                            dbz_d  = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            acc_d = {{HILO_W{1'b0}}, a_mag};
                            rem_d = '0;
                            opd_d = b_mag;
                        end
                    end else if (op_e == OP_MTHI) begin
                        hi_d = a;
                    end else begin
                        lo_d = a;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[HILO_W-1:1]};
                cnt_d = cnt_q - 5'd1;
            end
            DIV: begin
                acc_d = {acc_q[2*HILO_W-1:HILO_W], acc_q[HILO_W-2:0], div_q};
                rem_d = div_rem;
                cnt_d = cnt_q - 5'd1;
            end
            FIX: begin
                if (divop_q) begin
                    lo_d = neg_q  ? -acc_q[HILO_W-1:0] : acc_q[HILO_W-1:0];
                    hi_d = rneg_q ? -rem_q[HILO_W-1:0] : rem_q[HILO_W-1:0];
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d = 1'b1;
                cnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            divop_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            divop_q <= divop_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

`ifdef HILO_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: return {x % y, x / y};
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural model: an accepted op either completes at once or after a
    // fixed number of edges, during which further starts are ignored.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          m_done = 0, m_dbz = 0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_done = 0; m_dbz = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1: begin
                        m_dbz = 0;
                        {p_hi, p_lo} = ref_result(op, a, b);
                        if (MUL_LAT == 0) begin
                            m_hi = p_hi; m_lo = p_lo; m_done = 1;
                        end else begin
                            m_left = MUL_LAT;
                        end
                    end
                    3'd2, 3'd3: begin
                        m_dbz = 0;
                        if (b == 0) begin
                            m_dbz = 1; m_done = 1;
                        end else begin
                            {p_hi, p_lo} = ref_result(op, a, b);
                            m_left = DIV_LAT;
                        end
                    end
                    3'd4: begin m_hi = a; m_dbz = 0; end
                    3'd5: begin m_lo = a; m_dbz = 0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("hi",   hi,          m_hi);
            chk("lo",   lo,          m_lo);
            chk("busy", {31'd0, busy},        {31'd0, m_left > 0});
            chk("done", {31'd0, done},        {31'd0, m_done});
            chk("dbz",  {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 100);
    endtask

    task automatic pulse(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [63:0] r64;
    int          lat;

    initial begin
        // model pins
        r64 = ref_result(3'd0, 32'hFFFFFFFD, 32'd5);
        chk("ref_mult_hi", r64[63:32], 32'hFFFFFFFF);
        chk("ref_mult_lo", r64[31:0],  32'hFFFFFFF1);
        r64 = ref_result(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("ref_ovf_lo", r64[31:0],  32'h80000000);
        chk("ref_ovf_hi", r64[63:32], 32'h00000000);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hi",   hi, 32'd0);
        chk("rst_lo",   lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);

        issue(3'd0, 32'hFFFFFFFD, 32'd5, lat);
        chk("mult_lat", lat, MUL_LAT + 1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        issue(3'd2, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_lat", lat, 34);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIVU with an MTHI attempted mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        chk("divu_to", {31'd0, lat < 100}, 32'd1);
        chk("divu_lo", lo, 32'h0FFFFFFF);
        chk("divu_hi", hi, 32'h0000000F);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);

        pulse(3'd4, 32'h1234);
        chk("mthi", hi, 32'h1234);
        pulse(3'd5, 32'h5678);
        chk("mtlo", lo, 32'h5678);
        issue(3'd2, 32'h99, 32'd0, lat);
        chk("dbz_lat",  lat, 1);
        chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        chk("dbz_busy", {31'd0, busy}, 32'd0);
        chk("dbz_hi", hi, 32'h1234);
        chk("dbz_lo", lo, 32'h5678);
        @(negedge clk);
        chk("dbz_sticky", {31'd0, div_by_zero}, 32'd1);

        // MULTU aborted by reset
        pulse(3'd1, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_hi",   hi, 32'd0);
        chk("abort_lo",   lo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        issue(3'd1, 32'h10000, 32'h10000, lat);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'd0);

        // randomized traffic, including starts that land while busy
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b1;
            op    = 3'($urandom_range(0, 7));
            a     = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'd1;
                default: b = $urandom;
            endcase
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
